// File: rtl/hub_pkg.sv
// Shared definitions for the HUB floating-point datapath: FSM state type,
// exponent bias and field-slice helpers used by both the divider and the multiplier.
package hub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Excess-2^(E-1) exponent bias.
  function automatic int hub_bias(input int e);
    return 32'sd1 <<< (e - 1);
  endfunction

  // Field helpers take the operand zero-extended to 64 bits plus the field widths,
  // so one definition serves every format size.
  function automatic logic hub_sign(input logic [63:0] x, input int m, input int e);
    logic [63:0] t;
    t = x >> (m + e);
    return t[0];
  endfunction

  function automatic logic [63:0] hub_exp(input logic [63:0] x, input int m, input int e);
    return (x >> m) & ((64'd1 << e) - 64'd1);
  endfunction

  function automatic logic [63:0] hub_mant(input logic [63:0] x, input int m);
    return x & ((64'd1 << m) - 64'd1);
  endfunction

endpackage

// File: rtl/hub_div.sv
// Sequential HUB floating-point divider: radix-2 restoring division, one quotient
// bit per cycle, valid/ready handshake on input and output.
module hub_div
  import hub_pkg::*;
#(
  parameter int M = 23,
  parameter int E = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [E+M:0]     X,
  input  logic [E+M:0]     Y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [E+M:0]     Z,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(M + 1);

  state_t          r_state;
  logic            r_sign;
  logic [E-1:0]    r_exp;
  logic [M+1:0]    r_b;
  logic [M+2:0]    r_rem;
  logic [M-1:0]    r_q;
  logic [CW-1:0]   r_count;
  logic [E+M:0]    r_z;
  logic            r_out_valid;

  logic [M+1:0]    w_a;
  logic [M+1:0]    w_b;
  logic            w_lt;
  logic [E-1:0]    w_exp_x;
  logic [E-1:0]    w_exp_y;
  logic [E-1:0]    w_exp;
  logic [M+2:0]    w_rem_init;
  logic            w_ge;
  logic [M+2:0]    w_rem_sub;
  logic [M+2:0]    w_rem_next;
  logic [M-1:0]    w_q_next;

  // Operands with both implicit ones attached: {1, mantissa, ILSB}.
  assign w_a        = {1'b1, M'(hub_mant(64'(X), M)), 1'b1};
  assign w_b        = {1'b1, M'(hub_mant(64'(Y), M)), 1'b1};
  assign w_lt       = (w_a < w_b);
  assign w_rem_init = w_lt ? {w_a, 1'b0} : {1'b0, w_a};

  // Exponent arithmetic is modulo 2^E; wrap is intentionally silent.
  assign w_exp_x = E'(hub_exp(64'(X), M, E));
  assign w_exp_y = E'(hub_exp(64'(Y), M, E));
  assign w_exp   = w_exp_x - w_exp_y + E'(hub_bias(E)) - E'(w_lt);

  assign w_ge       = (r_rem >= {1'b0, r_b});
  assign w_rem_sub  = w_ge ? (r_rem - {1'b0, r_b}) : r_rem;
  assign w_rem_next = w_rem_sub << 1;

  // The integer quotient bit (count == M) is always 1 and never stored.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_q_next = r_q;
    if (r_count != CW'(M)) w_q_next[r_count] = w_ge;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_count     <= '0;
      r_z         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign  <= hub_sign(64'(X), M, E) ^ hub_sign(64'(Y), M, E);
            r_exp   <= w_exp;
            r_b     <= w_b;
            r_rem   <= w_rem_init;
            r_q     <= '0;
            r_count <= CW'(M);
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          if (r_count == '0) begin
            // Truncating the remainder is round-to-nearest in HUB format.
            r_z         <= {r_sign, r_exp, w_q_next};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign Z         = r_z;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_hub_div.sv
// Directed-vector bench for hub_div (M=23, E=8): quotient values, latency,
// output back-pressure and reset abort.
module tb_hub_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] X;
  logic [31:0] Y;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Z;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hub_div #(.M(23), .E(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .X         (X),
    .Y         (Y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Z         (Z),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division, check latency and result, optionally stall the output
  // for 'hold' cycles (with a stray in_valid that must be ignored), then drain.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z_exp, input int hold);
    int n;
    check($sformatf("%s/in_ready_idle", tag), 32'(in_ready), 32'd1);
    X        = x;
    Y        = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    X        = 32'hDEADBEEF;
    Y        = 32'h12345678;
    check($sformatf("%s/in_ready_calc", tag), 32'(in_ready), 32'd0);
    n = 1;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("%s/latency", tag), 32'(n), 32'd25);
    check($sformatf("%s/z", tag), Z, z_exp);
    check($sformatf("%s/in_ready_done", tag), 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      X        = 32'h3F800000;
      Y        = 32'h3F800000;
      tick();
      check($sformatf("%s/hold%0d_z", tag, i), Z, z_exp);
      check($sformatf("%s/hold%0d_valid", tag, i), 32'(out_valid), 32'd1);
      check($sformatf("%s/hold%0d_in_ready", tag, i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check($sformatf("%s/valid_after_hs", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s/in_ready_after_hs", tag), 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    X         = '0;
    Y         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst/in_ready_low", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/z", Z, 32'd0);
    check("rst/in_ready_still_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst/in_ready_after", 32'(in_ready), 32'd1);

    run_op("one_by_one", 32'h40000000, 32'h40000000, 32'h40000000, 0);
    run_op("sign_xor",   32'hC0000000, 32'h40000000, 32'hC0000000, 0);
    run_op("lt",         32'h40000000, 32'h407FFFFF, 32'h3F800000, 0);
    run_op("hub_trunc",  32'h40400000, 32'h40000000, 32'h403FFFFF, 0);
    run_op("exp_wrap",   32'h7F800000, 32'h00000000, 32'h3F800000, 0);
    run_op("backpress",  32'hC0400000, 32'h40000000, 32'hC03FFFFF, 5);

    // Abort an operation with reset ten cycles after accept.
    X        = 32'h40000000;
    Y        = 32'h40000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("abort/in_ready_in_rst", 32'(in_ready), 32'd0);
    check("abort/out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("abort/in_ready_after", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("abort/no_result", 32'(seen), 32'd0);
    run_op("after_abort", 32'h40400000, 32'h40000000, 32'h403FFFFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
